// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode/execute controls and the fetch/decode register outputs.
// master = fetch stage, slave = surrounding datapath (memory, decode, execute).
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_data;
    logic                  stall;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [31:0]           instr_out;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic [31:0]           fetch_count;
    logic [31:0]           flush_count;

    modport master (
        output imem_addr, instr_out, instr_pc, instr_valid, fetch_count, flush_count,
        input  imem_data, stall, branch_valid, branch_target
    );

    modport slave (
        input  imem_addr, instr_out, instr_pc, instr_valid, fetch_count, flush_count,
        output imem_data, stall, branch_valid, branch_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, registers imem words into the fetch/decode register, handles stall and branch squash.
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
//
// state    | meaning
// S_RESET  | held in reset / first cycle after release, nothing live yet
// S_RUN    | normal fetch, one word per unstalled cycle
// S_FLUSH  | redirect in progress, imem_addr shows the branch target
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  advance;
    logic                  taken;

    // Branch targets are word aligned by dropping the byte offset.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^bus.branch_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            pc_q    <= RESET_ADDR;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        advance = 1'b0;
        taken   = 1'b0;

        if (bus.branch_valid) begin
            taken   = 1'b1;
            pc_d    = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
            valid_d = 1'b0;
        end else if (bus.stall) begin
            if (state_q == S_FLUSH) begin
                valid_d = 1'b0;
            end
        end else begin
            advance = 1'b1;
            instr_d = bus.imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(4);
        end

        case (state_q)
            S_RESET: state_d = taken ? S_FLUSH : S_RUN;
            S_RUN:   state_d = taken ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = advance ? S_RUN : S_FLUSH;
            default: state_d = S_RESET;
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = valid_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (taken)   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.fetch_count = '0;
    assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, wrap and reset sequences, then randomized run vs reference model.
module tb_instruction_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0;
    logic reset1;

    instruction_fetch_if #(.ADDR_WIDTH(32)) bus0 ();
    instruction_fetch_if #(.ADDR_WIDTH(32)) bus1 ();

    instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(32)) u_dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.master)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .ADDR_WIDTH(32)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.master)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0000;
            32'h0000_0004: mem_word = 32'hE3A0_0008;
            32'h0000_001C: mem_word = 32'hDAFF_FFFE;
            default:       mem_word = {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
        endcase
    endfunction

    assign bus0.imem_data = mem_word(bus0.imem_addr);
    assign bus1.imem_data = mem_word(bus1.imem_addr);

    function automatic logic [31:0] perf(input logic [31:0] x);
`ifdef IFETCH_PERF_CNT_EN
        perf = x;
`else
        perf = x & 32'h0;
`endif
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        bv;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_out;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic st, input logic bv, input logic [31:0] tgt,
                                input logic [31:0] addr, input logic v, input logic [31:0] pc);
        vec_t r;
        r.stall   = st;
        r.bv      = bv;
        r.tgt     = tgt;
        r.e_addr  = addr;
        r.e_valid = v;
        r.e_pc    = pc;
        r.e_out   = mem_word(pc);
        return r;
    endfunction

    // Reference model: architectural view of the fetch stage, one call per clock edge.
    logic [31:0] m_pc, m_out, m_ipc, m_fc, m_flc;
    logic        m_valid;

    task automatic model_edge(input logic rst, input logic st, input logic bv, input logic [31:0] tgt);
        if (rst) begin
            m_pc = 32'h0; m_out = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_flc = 32'h0;
        end else if (bv) begin
            m_pc    = tgt & ~32'h3;
            m_valid = 1'b0;
            m_flc   = m_flc + 1;
        end else if (!st) begin
            m_out   = mem_word(m_pc);
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_fc    = m_fc + 1;
        end
    endtask

    task automatic cmp_model();
        chk("rand_addr",  bus0.imem_addr,   m_pc);
        chk("rand_valid", {31'h0, bus0.instr_valid}, {31'h0, m_valid});
        chk("rand_pc",    bus0.instr_pc,    m_ipc);
        chk("rand_out",   bus0.instr_out,   m_out);
        chk("rand_fcnt",  bus0.fetch_count, perf(m_fc));
        chk("rand_flcnt", bus0.flush_count, perf(m_flc));
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 32'h0,   32'h04,  1, 32'h00);
        tbl[1]  = mk(0, 0, 32'h0,   32'h08,  1, 32'h04);
        tbl[2]  = mk(0, 0, 32'h0,   32'h0C,  1, 32'h08);
        tbl[3]  = mk(1, 0, 32'h0,   32'h0C,  1, 32'h08);
        tbl[4]  = mk(1, 0, 32'h0,   32'h0C,  1, 32'h08);
        tbl[5]  = mk(1, 0, 32'h0,   32'h0C,  1, 32'h08);
        tbl[6]  = mk(0, 0, 32'h0,   32'h10,  1, 32'h0C);
        tbl[7]  = mk(0, 0, 32'h0,   32'h14,  1, 32'h10);
        tbl[8]  = mk(0, 0, 32'h0,   32'h18,  1, 32'h14);
        tbl[9]  = mk(0, 0, 32'h0,   32'h1C,  1, 32'h18);
        tbl[10] = mk(0, 0, 32'h0,   32'h20,  1, 32'h1C);
        tbl[11] = mk(0, 1, 32'h1E,  32'h1C,  0, 32'h0);
        tbl[12] = mk(0, 0, 32'h0,   32'h20,  1, 32'h1C);
        tbl[13] = mk(1, 1, 32'h103, 32'h100, 0, 32'h0);
        tbl[14] = mk(1, 0, 32'h0,   32'h100, 0, 32'h0);
        tbl[15] = mk(0, 1, 32'h200, 32'h200, 0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,   32'h204, 1, 32'h200);

        reset0 = 1'b1; reset1 = 1'b1;
        bus0.stall = 1'b0; bus0.branch_valid = 1'b0; bus0.branch_target = 32'h0;
        bus1.stall = 1'b0; bus1.branch_valid = 1'b0; bus1.branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // wrap-around from the top of the address space
        chk("wrap_rst_addr", bus1.imem_addr, 32'hFFFF_FFFC);
        reset1 = 1'b0;
        @(posedge clk); #1;
        chk("wrap_pc0",   bus1.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_v0",    {31'h0, bus1.instr_valid}, 32'h1);
        chk("wrap_addr0", bus1.imem_addr, 32'h0);
        @(posedge clk); #1;
        chk("wrap_pc1",   bus1.instr_pc, 32'h0);
        chk("wrap_addr1", bus1.imem_addr, 32'h4);

        // reset state and first cycle after release
        chk("rst_addr",  bus0.imem_addr, 32'h0);
        chk("rst_valid", {31'h0, bus0.instr_valid}, 32'h0);
        chk("rst_out",   bus0.instr_out, 32'h0);
        chk("rst_pc",    bus0.instr_pc, 32'h0);
        reset0 = 1'b0;
        #1;
        chk("rel_addr",  bus0.imem_addr, 32'h0);
        chk("rel_valid", {31'h0, bus0.instr_valid}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            bus0.stall         = tbl[i].stall;
            bus0.branch_valid  = tbl[i].bv;
            bus0.branch_target = tbl[i].tgt;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_addr", i), bus0.imem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, bus0.instr_valid}, {31'h0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), bus0.instr_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_out", i), bus0.instr_out, tbl[i].e_out);
            end
        end
        chk("vec_flush_count", bus0.flush_count, perf(32'd3));
        chk("vec_fetch_count", bus0.fetch_count, perf(32'd10));

        // mid-stream reset wins over stall and branch
        reset0 = 1'b1;
        bus0.stall = 1'b1; bus0.branch_valid = 1'b1; bus0.branch_target = 32'h40;
        @(posedge clk); #1;
        chk("mrst_valid", {31'h0, bus0.instr_valid}, 32'h0);
        chk("mrst_addr",  bus0.imem_addr, 32'h0);
        chk("mrst_fcnt",  bus0.fetch_count, 32'h0);
        chk("mrst_flcnt", bus0.flush_count, 32'h0);
        chk("mrst_out",   bus0.instr_out, 32'h0);

        model_edge(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_bv;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(63) == 0);
            r_st  = ($urandom_range(3) == 0);
            r_bv  = ($urandom_range(9) == 0);
            r_tgt = $urandom;
            reset0 = r_rst;
            bus0.stall = r_st;
            bus0.branch_valid = r_bv;
            bus0.branch_target = r_tgt;
            @(posedge clk);
            model_edge(r_rst, r_st, r_bv, r_tgt);
            #1;
            cmp_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-issue ARM datapath. Owns the program counter and drives the address of the combinational instruction memory. Registers the returned big-endian 32-bit word with its PC into the fetch/decode pipeline register. Handles decode stalls and execute-stage branch redirects with squash.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low 2 bits must be 0.
- `ADDR_WIDTH`, default 32: PC/address width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_addr`  out  ADDR_WIDTH: byte address to instruction memory; always equals internal PC register.
- `imem_data`  in  32: instruction word at `imem_addr`, valid combinationally in the same cycle.
- `stall`  in  1: decode cannot accept; hold PC and outputs.
- `branch_valid`  in  1: execute-stage redirect request, one-cycle pulse.
- `branch_target`  in  ADDR_WIDTH: redirect byte address; sampled when `branch_valid`=1.
- `instr_out`  out  32: registered instruction to decode.
- `instr_pc`  out  ADDR_WIDTH: byte address of `instr_out`.
- `instr_valid`  out  1: `instr_out`/`instr_pc` hold a live instruction.
- `fetch_count`  out  32: instructions delivered (see Configuration).
- `flush_count`  out  32: redirects taken (see Configuration).

## Operation

- State register `st`: `S_RESET`, `S_RUN`, `S_FLUSH`.
- `S_RESET`: entered while `reset`=1. PC←`RESET_PC`, `instr_out`←0, `instr_pc`←0, `instr_valid`←0, counters←0. Goes to `S_RUN` on the first edge with `reset`=0. During that first cycle `instr_valid` stays 0 and `imem_addr`=`RESET_PC`.
- `S_RUN`, priority per edge is reset > branch > stall > advance:
  - Branch: PC←{`branch_target`[ADDR_WIDTH-1:2],2'b00}; `instr_valid`←0 (squash the in-flight word); go to `S_FLUSH`.
  - Stall (no branch): PC, `instr_out`, `instr_pc`, `instr_valid` all hold.
  - Advance: `instr_out`←`imem_data`; `instr_pc`←PC; `instr_valid`←1; PC←PC+4.
- `S_FLUSH`: lasts one cycle; `imem_addr` shows the target.
  - Advance or stall rules as in `S_RUN`, but `instr_valid` stays 0 while stalled.
  - Returns to `S_RUN` on advance.
  - A new `branch_valid` re-redirects and remains in `S_FLUSH`.
- Arithmetic: PC+4 is modulo 2^ADDR_WIDTH. 32'hFFFF_FFFC+4 → 0, with no flag.
- Misaligned `branch_target`: low 2 bits are silently cleared.
- No reordering of instruction bytes: `imem_data` is already assembled big-endian (byte at addr → bits 31:24).

## Timing

- Fetch latency: address presented in cycle N → `instr_out` valid in cycle N+1.
- Branch penalty: `branch_valid` in cycle N → `imem_addr`=target in N+1 with `instr_valid`=0 → target instruction valid in N+2.
- Throughput: one instruction per cycle when `stall`=0 and no branches.
- `reset` asserted mid-stream: all outputs reach reset values at the next edge, regardless of `stall`/`branch_valid`.
- Outputs are purely registered, except `imem_addr`, which is the PC register output (no combinational path from inputs).

## Configuration

- `IFETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every advance edge that sets `instr_valid`←1.
  - `flush_count` increments on every edge where a branch is taken (outside reset).
  - Both wrap at 2^32 and are cleared by `reset`.
- Not defined: `fetch_count` and `flush_count` are tied to 0; no counter flops are synthesized.

## Test plan

- Reset release: `RESET_PC`=0, memory word0=0, word1=E3A00008.
  - Cycle 1: `imem_addr`=0, `instr_valid`=0.
  - Cycle 2: `instr_out`=0, `instr_pc`=0, valid=1.
  - Cycle 3: `instr_out`=E3A00008, `instr_pc`=4.
- Stall: assert `stall` for 3 cycles while `instr_pc`=8 → `instr_out`/`instr_pc`/`imem_addr` frozen at 8/8/12. After release, `instr_pc`=12 next cycle.
- Branch: `branch_valid`=1, target=0x1E, at `imem_addr`=0x20.
  - Next cycle: `imem_addr`=0x1C, `instr_valid`=0.
  - Following cycle: `instr_pc`=0x1C with mem[0x1C] (DAFFFFFE).
  - `flush_count`=1 with macro, 0 without.
- Branch with simultaneous `stall`=1 → redirect still taken: `imem_addr`=target the next cycle, `instr_valid`=0.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, run 2 advances → `instr_pc` sequence FFFF_FFFC then 0000_0000.
- Mid-stream reset after 5 fetches → next cycle `instr_valid`=0, `imem_addr`=`RESET_PC`, `fetch_count`=0.
